evm_ballot_ctrl: RTL and testbench

Ballot-issue controller that sits in front of the three-candidate EVM tally counter and sequences it. A presiding-officer button arms the machine for exactly one vote. The block then debounces the candidate buttons and rejects simultaneous presses, emits one clean vote pulse to the tally, and locks out until all buttons are released. On close of poll it raises the tally's voting-over input.

---
 rtl/evm_ballot_ctrl_if.sv | 25 ++
 rtl/evm_ballot_ctrl.sv | 146 ++++++++++++++
 tb/tb_evm_ballot_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/evm_ballot_ctrl_if.sv
// Purpose : bundles the EVM ballot controller's raw button inputs and tally-side outputs.
// Ports   : master = stimulus / officer panel side (drives buttons); slave = controller side.
// Notes   : all inputs are raw and asynchronous; the controller synchronizes them.
interface evm_ballot_ctrl_if;
   logic        ballot_btn;
   logic [2:0]  cand_btn;
   logic        close_poll;
   logic [2:0]  cand_out;
   logic        vote_strobe;
   logic        ballot_ready;
   logic        busy;
   logic        timeout_pulse;
   logic        voting_over;
   logic [15:0] votes_cast;

   modport master (
      output ballot_btn, cand_btn, close_poll,
      input  cand_out, vote_strobe, ballot_ready, busy, timeout_pulse, voting_over, votes_cast
   );

   modport slave (
      input  ballot_btn, cand_btn, close_poll,
      output cand_out, vote_strobe, ballot_ready, busy, timeout_pulse, voting_over, votes_cast
   );
endinterface

// File: rtl/evm_ballot_ctrl.sv
// Purpose : arms the EVM for exactly one vote per officer button press, debounces and
//           de-duplicates candidate buttons, issues one vote pulse, then locks out.
// Ports   : clk, rst (async active-low), bus (slave modport: buttons in, tally controls out).
// Latency : ballot rise -> ARMED 2 edges after sampling; one-hot press -> CAST after
//           DEBOUNCE_CYCLES+1 edges; all outputs registered or decoded from registered state.
module evm_ballot_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int LOCKOUT_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES  = 1000
) (
   input  logic             clk,
   input  logic             rst,
   evm_ballot_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, ARMED, DEBOUNCE, CAST, LOCKOUT, CLOSED} state_t;

   localparam logic [8:0]  DEB_LIM = 9'(DEBOUNCE_CYCLES);
   localparam logic [8:0]  LCK_LIM = 9'(LOCKOUT_CYCLES);
   localparam logic [20:0] TMO_LIM = 21'(TIMEOUT_CYCLES);

   state_t      state, state_nxt;
   logic [2:0]  ballot_sync;   // [1] is the synchronized level, [2] the edge-detect history
   logic [1:0]  close_sync;
   logic [2:0]  cand_s1, cand_s2;
   logic        ballot_rise, close_req, cand_one_hot;
   logic [2:0]  cand_q, cand_nxt;
   logic [7:0]  dbc_q, dbc_nxt;
   logic [7:0]  lock_q, lock_nxt;
   logic [19:0] timer_q, timer_nxt;
   logic        tmo_q, tmo_nxt;
   logic [15:0] votes_q;
   logic [8:0]  dbc_inc, lock_inc;
   logic [20:0] timer_inc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ballot_sync <= '0;
         close_sync  <= '0;
         cand_s1     <= '0;
         cand_s2     <= '0;
      end else begin
         ballot_sync <= {ballot_sync[1:0], bus.ballot_btn};
         close_sync  <= {close_sync[0], bus.close_poll};
         cand_s1     <= bus.cand_btn;
         cand_s2     <= cand_s1;
      end
   end

   assign ballot_rise  = ballot_sync[1] & ~ballot_sync[2];
   assign close_req    = close_sync[1];
   assign cand_one_hot = (cand_s2 != 3'b000) && ((cand_s2 & (cand_s2 - 3'd1)) == 3'b000);

   // Increments are one bit wider so the limit compare never sees a wrapped value.
   assign dbc_inc   = {1'b0, dbc_q} + 9'd1;
   assign lock_inc  = {1'b0, lock_q} + 9'd1;
   assign timer_inc = {1'b0, timer_q} + 21'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cand_q  <= '0;
         dbc_q   <= '0;
         lock_q  <= '0;
         timer_q <= '0;
         tmo_q   <= 1'b0;
         votes_q <= '0;
      end else begin
         state   <= state_nxt;
         cand_q  <= cand_nxt;
         dbc_q   <= dbc_nxt;
         lock_q  <= lock_nxt;
         timer_q <= timer_nxt;
         tmo_q   <= tmo_nxt;
         if (state == CAST && votes_q != 16'hFFFF)
            votes_q <= votes_q + 16'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      cand_nxt  = cand_q;
      dbc_nxt   = dbc_q;
      lock_nxt  = lock_q;
      timer_nxt = timer_q;
      tmo_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (close_req) begin
               state_nxt = CLOSED;
            end else if (ballot_rise) begin
               state_nxt = ARMED;
               timer_nxt = '0;
               dbc_nxt   = '0;
            end
         end
         ARMED, DEBOUNCE: begin
            // The timer counts cycles of the whole armed window, ARMED and DEBOUNCE alike.
            timer_nxt = timer_inc[19:0];
            if (close_req) begin
               state_nxt = CLOSED;
            end else if (timer_inc >= TMO_LIM) begin
               state_nxt = IDLE;
               tmo_nxt   = 1'b1;
               dbc_nxt   = '0;
            end else if (state == DEBOUNCE && cand_s2 == cand_q) begin
               if (dbc_inc >= DEB_LIM)
                  state_nxt = CAST;
               else
                  dbc_nxt = dbc_inc[7:0];
            end else if (cand_one_hot) begin
               // New or changed single press: (re)latch and restart the debounce count.
               // A one-cycle debounce is already satisfied by this first sample.
               cand_nxt  = cand_s2;
               dbc_nxt   = 8'd1;
               state_nxt = (DEB_LIM <= 9'd1) ? CAST : DEBOUNCE;
            end else begin
               state_nxt = ARMED;
               dbc_nxt   = '0;
            end
         end
         CAST: begin
            state_nxt = LOCKOUT;
            lock_nxt  = '0;
         end
         LOCKOUT: begin
            // The count parks once the minimum dead time is met; exit then waits for release.
            if (lock_inc >= LCK_LIM) begin
               if (cand_s2 == 3'b000)
                  state_nxt = close_req ? CLOSED : IDLE;
            end else begin
               lock_nxt = lock_inc[7:0];
            end
         end
         CLOSED:  state_nxt = CLOSED;
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.cand_out      = (state == CAST) ? cand_q : 3'b000;
   assign bus.vote_strobe   = (state == CAST);
   assign bus.ballot_ready  = (state == ARMED) || (state == DEBOUNCE);
   assign bus.busy          = (state == CAST) || (state == LOCKOUT);
   assign bus.timeout_pulse = tmo_q;
   assign bus.voting_over   = (state == CLOSED);
   assign bus.votes_cast    = votes_q;
endmodule

// File: tb/tb_evm_ballot_ctrl.sv
// Purpose : directed self-checking bench for evm_ballot_ctrl (vote, dual press, lockout,
//           timeout, close of poll, async reset, saturation).
// Ports   : none; drives two instances (1000- and 50-cycle timeout) through interfaces.
// Notes   : inputs change and outputs are sampled on the falling clock edge.
module tb_evm_ballot_ctrl;
   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   n_strobe;
   int   n_strobe_t;
   int   n_tmo_t;

   evm_ballot_ctrl_if bus();
   evm_ballot_ctrl_if bus_t();

   evm_ballot_ctrl #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(16), .TIMEOUT_CYCLES(1000)) dut (
      .clk(clk), .rst(rst), .bus(bus));

   evm_ballot_ctrl #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(16), .TIMEOUT_CYCLES(50)) dut_t (
      .clk(clk), .rst(rst), .bus(bus_t));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.vote_strobe)     n_strobe++;
      if (bus_t.vote_strobe)   n_strobe_t++;
      if (bus_t.timeout_pulse) n_tmo_t++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      bus.ballot_btn = 1'b0;   bus.cand_btn = 3'b000;   bus.close_poll = 1'b0;
      bus_t.ballot_btn = 1'b0; bus_t.cand_btn = 3'b000; bus_t.close_poll = 1'b0;
      tick(2);
      rst = 1'b1;
      tick(1);
   endtask

   // One-cycle officer pulse; returns at the falling edge where ARMED is first visible.
   task automatic arm();
      bus.ballot_btn = 1'b1;
      tick(1);
      bus.ballot_btn = 1'b0;
      tick(2);
   endtask

   // Holds cand_btn=c and reports the falling-edge index (1-based) of the vote strobe.
   task automatic press_wait(input logic [2:0] c, output int k_seen, output logic [2:0] c_seen);
      k_seen = 0;
      c_seen = 3'b000;
      bus.cand_btn = c;
      for (int k = 1; k <= 12; k++) begin
         tick(1);
         if (bus.vote_strobe) begin
            k_seen = k;
            c_seen = bus.cand_out;
            break;
         end
      end
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 100; i++) begin
         if (!bus.busy) break;
         tick(1);
      end
      chk(tag, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int         k;
      int         base;
      int         first;
      logic [2:0] c;
      logic       r49, r50;

      total = 0; bad = 0; n_strobe = 0; n_strobe_t = 0; n_tmo_t = 0;
      do_reset();

      // Reset state
      chk("rst_cand_out", 32'(bus.cand_out), 32'd0);
      chk("rst_strobe", 32'(bus.vote_strobe), 32'd0);
      chk("rst_ready", 32'(bus.ballot_ready), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_tmo", 32'(bus.timeout_pulse), 32'd0);
      chk("rst_over", 32'(bus.voting_over), 32'd0);
      chk("rst_votes", 32'(bus.votes_cast), 32'd0);

      // Basic vote for candidate 2 with exact latency and lockout length
      base = n_strobe;
      bus.ballot_btn = 1'b1;
      tick(1);
      bus.ballot_btn = 1'b0;
      tick(1);
      chk("t1_ready_n1", 32'(bus.ballot_ready), 32'd0);
      tick(1);
      chk("t1_ready_n2", 32'(bus.ballot_ready), 32'd1);
      press_wait(3'b010, k, c);
      chk("t1_latency", 32'(k), 32'd6);
      chk("t1_cand", 32'(c), 32'b010);
      chk("t1_busy_cast", 32'(bus.busy), 32'd1);
      tick(4);
      bus.cand_btn = 3'b000;
      tick(12);
      chk("t1_busy_last", 32'(bus.busy), 32'd1);
      tick(1);
      chk("t1_busy_end", 32'(bus.busy), 32'd0);
      chk("t1_ready_end", 32'(bus.ballot_ready), 32'd0);
      chk("t1_votes", 32'(bus.votes_cast), 32'd1);
      chk("t1_strobes", 32'(n_strobe - base), 32'd1);

      // Dual press is ignored, then a single press votes
      do_reset();
      base = n_strobe;
      arm();
      bus.cand_btn = 3'b011;
      tick(50);
      chk("t2_dual_strobes", 32'(n_strobe - base), 32'd0);
      chk("t2_dual_ready", 32'(bus.ballot_ready), 32'd1);
      press_wait(3'b001, k, c);
      chk("t2_latency", 32'(k), 32'd6);
      chk("t2_cand", 32'(c), 32'b001);
      bus.cand_btn = 3'b000;
      wait_idle("t2_idle");
      chk("t2_votes", 32'(bus.votes_cast), 32'd1);
      chk("t2_strobes", 32'(n_strobe - base), 32'd1);

      // No ballot -> no vote; held button plus ballot in LOCKOUT -> no second vote
      do_reset();
      base = n_strobe;
      bus.cand_btn = 3'b100;
      tick(20);
      chk("t3_noballot_strobes", 32'(n_strobe - base), 32'd0);
      chk("t3_noballot_votes", 32'(bus.votes_cast), 32'd0);
      bus.cand_btn = 3'b000;
      tick(3);
      arm();
      press_wait(3'b100, k, c);
      chk("t3_cand", 32'(c), 32'b100);
      tick(3);
      bus.ballot_btn = 1'b1;
      tick(1);
      bus.ballot_btn = 1'b0;
      tick(60);
      chk("t3_held_busy", 32'(bus.busy), 32'd1);
      bus.cand_btn = 3'b000;
      wait_idle("t3_idle");
      tick(5);
      chk("t3_not_queued", 32'(bus.ballot_ready), 32'd0);
      chk("t3_strobes", 32'(n_strobe - base), 32'd1);
      chk("t3_votes", 32'(bus.votes_cast), 32'd1);

      // Timeout on the 50-cycle instance
      do_reset();
      first = 0; r49 = 1'b0; r50 = 1'b1;
      bus_t.ballot_btn = 1'b1;
      tick(1);
      bus_t.ballot_btn = 1'b0;
      tick(2);
      chk("t4_ready", 32'(bus_t.ballot_ready), 32'd1);
      for (int j = 1; j <= 60; j++) begin
         tick(1);
         if (bus_t.timeout_pulse && first == 0) first = j;
         if (j == 49) r49 = bus_t.ballot_ready;
         if (j == 50) r50 = bus_t.ballot_ready;
      end
      chk("t4_tmo_cycle", 32'(first), 32'd50);
      chk("t4_tmo_count", 32'(n_tmo_t), 32'd1);
      chk("t4_ready_49", 32'(r49), 32'd1);
      chk("t4_ready_50", 32'(r50), 32'd0);
      bus_t.cand_btn = 3'b001;
      tick(20);
      bus_t.cand_btn = 3'b000;
      chk("t4_late_strobes", 32'(n_strobe_t), 32'd0);
      chk("t4_late_votes", 32'(bus_t.votes_cast), 32'd0);

      // Close of poll during LOCKOUT lets the vote finish, then CLOSED absorbs everything
      do_reset();
      base = n_strobe;
      arm();
      press_wait(3'b001, k, c);
      chk("t5_cand", 32'(c), 32'b001);
      tick(2);
      bus.close_poll = 1'b1;
      bus.cand_btn = 3'b000;
      for (int i = 0; i < 100; i++) begin
         if (bus.voting_over) break;
         tick(1);
      end
      chk("t5_over", 32'(bus.voting_over), 32'd1);
      chk("t5_votes", 32'(bus.votes_cast), 32'd1);
      chk("t5_busy", 32'(bus.busy), 32'd0);
      arm();
      press_wait(3'b010, k, c);
      bus.cand_btn = 3'b000;
      chk("t5_closed_novote", 32'(k), 32'd0);
      chk("t5_closed_ready", 32'(bus.ballot_ready), 32'd0);
      chk("t5_closed_strobes", 32'(n_strobe - base), 32'd1);
      #3 rst = 1'b0;
      #1;
      chk("t5_rst_over", 32'(bus.voting_over), 32'd0);
      chk("t5_rst_votes", 32'(bus.votes_cast), 32'd0);
      bus.close_poll = 1'b0;
      tick(1);

      // Reset in the middle of the CAST cycle truncates the pulse
      do_reset();
      arm();
      press_wait(3'b100, k, c);
      chk("t6_strobe_seen", 32'(k), 32'd6);
      #2 rst = 1'b0;
      #1;
      chk("t6_trunc_strobe", 32'(bus.vote_strobe), 32'd0);
      chk("t6_trunc_cand", 32'(bus.cand_out), 32'd0);
      tick(1);
      rst = 1'b1;
      tick(10);
      bus.cand_btn = 3'b000;
      chk("t6_votes_after", 32'(bus.votes_cast), 32'd0);

      // Saturation of the vote counter
      do_reset();
      force dut.votes_q = 16'hFFFE;
      tick(1);
      release dut.votes_q;
      tick(1);
      chk("t7_preload", 32'(bus.votes_cast), 32'hFFFE);
      arm();
      press_wait(3'b010, k, c);
      chk("t7_cand_a", 32'(c), 32'b010);
      bus.cand_btn = 3'b000;
      wait_idle("t7_idle_a");
      chk("t7_votes_a", 32'(bus.votes_cast), 32'hFFFF);
      arm();
      press_wait(3'b001, k, c);
      chk("t7_cand_b", 32'(c), 32'b001);
      bus.cand_btn = 3'b000;
      wait_idle("t7_idle_b");
      chk("t7_votes_sat", 32'(bus.votes_cast), 32'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end
endmodule
